// File: rtl/lspc_timer_irq.sv
// LSPC raster timers and 68k interrupt level encoder.
// Optional counter readback is compiled in with LSPC_TIMER_READBACK_EN.

module lspc_timer_ch #(
  parameter int TW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pix_i,
  input  logic          run_i,
  input  logic          vbl_i,
  input  logic          wr_mode_i,
  input  logic          wr_hi_i,
  input  logic          wr_lo_i,
  input  logic [15:0]   wdata_i,
  output logic [3:0]    ctrl_o,
  output logic [TW-1:0] load_o,
  output logic [15:0]   rb_o,
  output logic          fire_o,
  output logic          tzero_o
);
  logic [2:0]    mode_q, mode_d;
  logic          en_q, en_d, armed_q, armed_d;
  logic [TW-1:0] load_q, load_d, cnt_q, cnt_d;
  logic [31:0]   ld32;

  always_comb begin
    mode_d  = mode_q;
    en_d    = en_q;
    ld32    = 32'(load_q);
    fire_o  = 1'b0;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (wr_mode_i) {en_d, mode_d} = wdata_i[3:0];
    if (wr_hi_i)   ld32[31:16] = wdata_i;
    if (wr_lo_i)   ld32[15:0]  = wdata_i;
    load_d = ld32[TW-1:0];
    // Write-load beats VBL reload beats expiry beats decrement.
    if (wr_lo_i && mode_q[0]) begin
      cnt_d   = load_d;
      armed_d = 1'b1;
    end else if (vbl_i && mode_q[1]) begin
      cnt_d   = load_q;
      armed_d = 1'b1;
    end else if (pix_i && run_i) begin
      if (cnt_q == '0) begin
        if (armed_q) begin
          fire_o = en_q;
          if (mode_q[2]) cnt_d   = load_q;
          else           armed_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - {{(TW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= '0;
      en_q    <= 1'b0;
      load_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      en_q    <= en_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign ctrl_o  = {en_q, mode_q};
  assign load_o  = load_q;
  assign tzero_o = (cnt_q == '0);
`ifdef LSPC_TIMER_READBACK_EN
  assign rb_o = cnt_q[15:0];
`else
  assign rb_o = 16'h0000;
`endif
endmodule

module lspc_timer_irq #(
  parameter int NCH        = 2,
  parameter int TW         = 32,
  parameter int VIDEO_MODE = 1
) (
  input  logic           CLK_24M,
  input  logic           RESET,
  input  logic           PIX_EN,
  input  logic [8:0]     VCOUNT,
  input  logic           VBL_START,
  input  logic           REG_WE,
  input  logic [4:0]     REG_ADDR,
  input  logic [15:0]    REG_WDATA,
  output logic [15:0]    REG_RDATA,
  output logic [2:0]     IPL,
  output logic [NCH-1:0] TZERO
);
  localparam int PW = NCH + 2;

  logic [PW-1:0]             pend_q, pend_d, ack;
  logic [2:0]                ipl_q, ipl_d;
  logic                      stop_q, boot_q, border, run;
  logic [NCH-1:0]            wr_mode, wr_hi, wr_lo, fire;
  logic [NCH-1:0][3:0]       ctrl;
  logic [NCH-1:0][TW-1:0]    load;
  logic [NCH-1:0][15:0]      rb;
  logic [4:0]                off;
  logic [31:0]               lw;
  logic                      unused_vc;

  assign unused_vc = ^VCOUNT[3:0];
  assign border    = (VCOUNT[7:4] == 4'h0) || (VCOUNT[7:4] == 4'hF);
  assign run       = VCOUNT[8] & ~((VIDEO_MODE != 0) & stop_q & border);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [4:0] BASE = 5'(4 + 4*c);
    assign wr_mode[c] = REG_WE && (REG_ADDR == BASE);
    assign wr_hi[c]   = REG_WE && (REG_ADDR == BASE + 5'd1);
    assign wr_lo[c]   = REG_WE && (REG_ADDR == BASE + 5'd2);
    lspc_timer_ch #(.TW(TW)) u_ch (
      .clk_i(CLK_24M), .rst_i(RESET), .pix_i(PIX_EN), .run_i(run), .vbl_i(VBL_START),
      .wr_mode_i(wr_mode[c]), .wr_hi_i(wr_hi[c]), .wr_lo_i(wr_lo[c]), .wdata_i(REG_WDATA),
      .ctrl_o(ctrl[c]), .load_o(load[c]), .rb_o(rb[c]), .fire_o(fire[c]), .tzero_o(TZERO[c])
    );
  end

  // A set landing on the same bit as an ack wins.
  always_comb begin
    ack    = (REG_WE && REG_ADDR == 5'd0) ? REG_WDATA[PW-1:0] : '0;
    pend_d = (pend_q & ~ack) | {boot_q, fire, VBL_START};
    ipl_d  = 3'd0;
    for (int i = 0; i < PW; i++)
      if (pend_q[i]) ipl_d = 3'(i + 1);
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      pend_q <= '0;
      ipl_q  <= 3'd0;
      stop_q <= 1'b0;
      boot_q <= 1'b1;
    end else begin
      pend_q <= pend_d;
      ipl_q  <= ipl_d;
      boot_q <= 1'b0;
      if (REG_WE && REG_ADDR == 5'd1) stop_q <= REG_WDATA[0];
    end
  end

  assign IPL = ipl_q;

  always_comb begin
    REG_RDATA = 16'h0000;
    off       = REG_ADDR - 5'd4;
    lw        = 32'h0;
    if (REG_ADDR == 5'd0)      REG_RDATA = 16'(pend_q);
    else if (REG_ADDR == 5'd1) REG_RDATA = {15'h0, stop_q};
    else if (REG_ADDR >= 5'd4) begin
      for (int c = 0; c < NCH; c++) begin
        if (off[4:2] == 3'(c)) begin
          lw = 32'(load[c]);
          case (off[1:0])
            2'd0:    REG_RDATA = {12'h0, ctrl[c]};
            2'd1:    REG_RDATA = lw[31:16];
            2'd2:    REG_RDATA = lw[15:0];
            default: REG_RDATA = rb[c];
          endcase
        end
      end
    end
  end
endmodule
